// File: rtl/booth_multiplier_r4.sv
// booth_multiplier_r4: multi-cycle radix-4 (modified) Booth multiplier.
// Retires two multiplier bits per cycle and supports signed or unsigned operands.
// It uses a start/busy/done handshake, and product holds the last result.
// Optional macro DEBUG_PORTS_EN exposes the live internal registers as extra outputs.
module booth_multiplier_r4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef DEBUG_PORTS_EN
  ,
  output logic [WIDTH+3:0]                   a_dbg,
  output logic [WIDTH+1:0]                   q_dbg,
  output logic                               q_1_dbg,
  output logic [$clog2((WIDTH+2)/2+1)-1:0]   iter_dbg
`endif
);

  localparam int EXT  = WIDTH + 2;
  localparam int ITER = EXT / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [EXT+1:0] a;
  logic [EXT-1:0] q;
  logic [EXT-1:0] m;
  logic           q_1;
  logic [CW-1:0]  iter;

  logic [EXT+1:0] m_wide;
  logic [EXT+1:0] addend;
  logic [EXT+1:0] sum;
  logic [EXT+1:0] a_next;
  logic [EXT-1:0] q_next;
  logic           q_1_next;

  // One radix-4 step: recode the bit triple, add the partial product, then shift right by two.
  always_comb begin
    m_wide = {{2{m[EXT-1]}}, m};
    addend = '0;
    unique case ({q[1:0], q_1})
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = -(m_wide << 1);
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;
    endcase
    sum      = a + addend;
    a_next   = {{2{sum[EXT+1]}}, sum[EXT+1:2]};
    q_next   = {sum[1:0], q[EXT-1:2]};
    q_1_next = q[1];
  end

  // Control FSM and datapath registers; load on accepted start, iterate, then publish the product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      iter    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                 : {2'b00, multiplicand};
            q     <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                 : {2'b00, multiplier};
            a     <= '0;
            q_1   <= 1'b0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          a    <= a_next;
          q    <= q_next;
          q_1  <= q_1_next;
          iter <= iter + 1'b1;
          if (iter == LAST) begin
            product <= {a_next[WIDTH-3:0], q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DEBUG_PORTS_EN
  // Expose the live datapath registers for observation.
  always_comb begin
    a_dbg    = a;
    q_dbg    = q;
    q_1_dbg  = q_1;
    iter_dbg = iter;
  end
`endif

endmodule
